// File: rtl/sys_defs.sv
// ============================================================================
// sys_defs : shared pipeline types for the multiplier result path
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef SYS_DEFS_MACROS
`define SYS_DEFS_MACROS
`define B_MASK_REG_WIDTH 4
`define ALU_num 2
`endif

package sys_defs;

   localparam int B_MASK_W  = `B_MASK_REG_WIDTH;
   localparam int ALU_NUM   = `ALU_num;
   localparam int BR_NUM_W  = $clog2(B_MASK_W);
   localparam int PRN_W     = 6;
   localparam int ROB_W     = 5;
   localparam int DATA_XLEN = 32;

   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULH   = 2'd1,
      MULHSU = 2'd2,
      MULHU  = 2'd3
   } MUL_FUNC;

   typedef struct packed {
      logic                valid;
      logic [B_MASK_W-1:0] is_b_mask;
      logic [PRN_W-1:0]    dest_prn;
      logic [ROB_W-1:0]    rob_idx;
      MUL_FUNC             mul_func;
   } IS_EX_PACKET;

   typedef struct packed {
      logic [DATA_XLEN-1:0] value;
      logic [PRN_W-1:0]     dest_prn;
      logic [ROB_W-1:0]     rob_idx;
      logic [B_MASK_W-1:0]  b_mask;
   } MUL_CDB_PACKET;

   // Drop the dependency on every branch that resolved correctly this cycle.
   function automatic logic [B_MASK_W-1:0] clear_resolved(
      input logic [B_MASK_W-1:0]              mask,
      input logic [ALU_NUM-1:0]               en,
      input logic [ALU_NUM-1:0][BR_NUM_W-1:0] num
   );
      logic [B_MASK_W-1:0] m;
      m = mask;
      for (int j = 0; j < ALU_NUM; j++) begin
         if (en[j]) m[num[j]] = 1'b0;
      end
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mul_result_select.sv
// ============================================================================
// mul_result_select : picks the low or high product word for the writeback
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_result_select
   import sys_defs::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] i_product,
   input  MUL_FUNC           i_func,
   output logic [XLEN-1:0]   o_value
);

   always_comb begin
      o_value = i_product[XLEN-1:0];
      case (i_func)
         MULH, MULHSU, MULHU: o_value = i_product[2*XLEN-1:XLEN];
         default:             o_value = i_product[XLEN-1:0];
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mult_result_buffer.sv
// ============================================================================
// mult_result_buffer : branch-aware result FIFO between multiplier and CDB
// Rev 1.0
// ============================================================================
`default_nettype none

module mult_result_buffer
   import sys_defs::*;
#(
   parameter int XLEN      = 32,
   parameter int DEPTH     = 4,
   parameter int NUM_STAGE = 4
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             mul_done,
   input  logic [2*XLEN-1:0]                mul_product,
   input  IS_EX_PACKET                      mul_packet,
   input  logic                             clean_brat_en,
   input  logic [BR_NUM_W-1:0]              clean_brat_num,
   input  logic [ALU_NUM-1:0]               clean_bit_brat_en,
   input  logic [ALU_NUM-1:0][BR_NUM_W-1:0] clean_bit_brat_num,
   input  logic                             cdb_gnt,
   output logic                             cdb_req,
   output MUL_CDB_PACKET                    cdb_packet,
   output logic [$clog2(DEPTH):0]           free_cnt,
   output logic                             overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   // Issue credits must fit in the buffer; kept visible for integrators.
   logic w_unused_num_stage;
   assign w_unused_num_stage = (NUM_STAGE <= DEPTH);

   MUL_CDB_PACKET    r_ent [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_free;
   logic             r_overflow;

   logic [XLEN-1:0]  w_sel_value;
   MUL_CDB_PACKET    w_new;
   MUL_CDB_PACKET    w_head;
   logic             w_nonempty;
   logic             w_full;
   logic             w_head_squash;
   logic             w_req;
   logic             w_pop;
   logic             w_in_squash;
   logic             w_push_req;
   logic             w_push;
   logic             w_ovf_set;
   logic [CNT_W-1:0] w_count_nxt;

   mul_result_select #(
      .XLEN (XLEN)
   ) u_select (
      .i_product (mul_product),
      .i_func    (mul_packet.mul_func),
      .o_value   (w_sel_value)
   );

   always_comb begin
      w_new          = '0;
      w_new.value    = w_sel_value;
      w_new.dest_prn = mul_packet.dest_prn;
      w_new.rob_idx  = mul_packet.rob_idx;
      w_new.b_mask   = clear_resolved(mul_packet.is_b_mask, clean_bit_brat_en,
                                      clean_bit_brat_num);

      w_head        = r_ent[r_head];
      w_nonempty    = (r_count != '0);
      w_full        = (r_count == CNT_W'(DEPTH));
      // A squash landing on the head wins over any grant in the same cycle.
      w_head_squash = clean_brat_en && w_head.b_mask[clean_brat_num];
      w_req         = w_nonempty && r_valid[r_head] && !w_head_squash;
      w_pop         = (w_req && cdb_gnt) || (w_nonempty && !r_valid[r_head]);

      w_in_squash   = clean_brat_en && mul_packet.is_b_mask[clean_brat_num];
      w_push_req    = mul_done && mul_packet.valid && !w_in_squash;
      w_push        = w_push_req && (!w_full || w_pop);
      w_ovf_set     = w_push_req && w_full && !w_pop;

      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_free     <= CNT_W'(DEPTH);
         r_overflow <= 1'b0;
         r_valid    <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            r_ent[i].b_mask <= clear_resolved(r_ent[i].b_mask, clean_bit_brat_en,
                                              clean_bit_brat_num);
            if (clean_brat_en && r_ent[i].b_mask[clean_brat_num]) r_valid[i] <= 1'b0;
         end
         // The tail write comes last so it overrides any update to a recycled slot.
         if (w_push) begin
            r_ent[r_tail]   <= w_new;
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + PTR_W'(1);
         end
         if (w_pop) r_head <= r_head + PTR_W'(1);
         r_count <= w_count_nxt;
         r_free  <= CNT_W'(DEPTH) - w_count_nxt;
         if (w_ovf_set) r_overflow <= 1'b1;
      end
   end

   assign cdb_req    = w_req;
   assign cdb_packet = w_nonempty ? w_head : '0;
   assign free_cnt   = r_free;
   assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_mult_result_buffer.sv
// ============================================================================
// tb_mult_result_buffer : directed self-checking bench for mult_result_buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mult_result_buffer;
   import sys_defs::*;

   localparam int XLEN      = 32;
   localparam int DEPTH     = 4;
   localparam int NUM_STAGE = 4;

   logic                             clock = 1'b0;
   logic                             reset;
   logic                             mul_done;
   logic [2*XLEN-1:0]                mul_product;
   IS_EX_PACKET                      mul_packet;
   logic                             clean_brat_en;
   logic [BR_NUM_W-1:0]              clean_brat_num;
   logic [ALU_NUM-1:0]               clean_bit_brat_en;
   logic [ALU_NUM-1:0][BR_NUM_W-1:0] clean_bit_brat_num;
   logic                             cdb_gnt;
   logic                             cdb_req;
   MUL_CDB_PACKET                    cdb_packet;
   logic [$clog2(DEPTH):0]           free_cnt;
   logic                             overflow;

   int n_pass  = 0;
   int n_total = 0;

   mult_result_buffer #(
      .XLEN      (XLEN),
      .DEPTH     (DEPTH),
      .NUM_STAGE (NUM_STAGE)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .mul_done           (mul_done),
      .mul_product        (mul_product),
      .mul_packet         (mul_packet),
      .clean_brat_en      (clean_brat_en),
      .clean_brat_num     (clean_brat_num),
      .clean_bit_brat_en  (clean_bit_brat_en),
      .clean_bit_brat_num (clean_bit_brat_num),
      .cdb_gnt            (cdb_gnt),
      .cdb_req            (cdb_req),
      .cdb_packet         (cdb_packet),
      .free_cnt           (free_cnt),
      .overflow           (overflow)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      mul_done           = 1'b0;
      mul_product        = '0;
      mul_packet         = '0;
      clean_brat_en      = 1'b0;
      clean_brat_num     = '0;
      clean_bit_brat_en  = '0;
      clean_bit_brat_num = '0;
      cdb_gnt            = 1'b0;
   endtask

   task automatic push(input MUL_FUNC f, input logic [2*XLEN-1:0] prod,
                       input logic [B_MASK_W-1:0] mask, input int rob);
      mul_done             = 1'b1;
      mul_product          = prod;
      mul_packet           = '0;
      mul_packet.valid     = 1'b1;
      mul_packet.is_b_mask = mask;
      mul_packet.dest_prn  = PRN_W'(rob + 32);
      mul_packet.rob_idx   = ROB_W'(rob);
      mul_packet.mul_func  = f;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_total++; if (cdb_req !== 1'b0) $display("FAIL rst_req: got %b want 0", cdb_req); else n_pass++;
      n_total++; if (free_cnt !== 3'd4) $display("FAIL rst_free: got %0d want 4", free_cnt); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", overflow); else n_pass++;
      n_total++; if (cdb_packet !== '0) $display("FAIL rst_pkt: got %h want 0", cdb_packet); else n_pass++;
   endtask

   task automatic test_select();
      MUL_FUNC         funcs [4] = '{MUL, MULH, MULHSU, MULHU};
      logic [XLEN-1:0] exp   [4] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
      for (int k = 0; k < 4; k++) begin
         idle();
         push(funcs[k], 64'hFFFF_FFFE_0000_0001, 4'b0000, k + 1);
         cdb_gnt = 1'b1;
         tick();
         idle();
         cdb_gnt = 1'b1;
         n_total++; if (cdb_req !== 1'b1) $display("FAIL sel_req[%0d]: got %b want 1", k, cdb_req); else n_pass++;
         n_total++; if (cdb_packet.value !== exp[k]) $display("FAIL sel_value[%0d]: got %h want %h", k, cdb_packet.value, exp[k]); else n_pass++;
         n_total++; if (cdb_packet.rob_idx !== ROB_W'(k + 1)) $display("FAIL sel_rob[%0d]: got %0d want %0d", k, cdb_packet.rob_idx, k + 1); else n_pass++;
         n_total++; if (cdb_packet.dest_prn !== PRN_W'(k + 33)) $display("FAIL sel_prn[%0d]: got %0d want %0d", k, cdb_packet.dest_prn, k + 33); else n_pass++;
         tick();
         n_total++; if (cdb_req !== 1'b0 || free_cnt !== 3'd4) $display("FAIL sel_drain[%0d]: got req=%b free=%0d want req=0 free=4", k, cdb_req, free_cnt); else n_pass++;
      end
   endtask

   task automatic test_fill_overflow();
      idle();
      for (int k = 0; k < 4; k++) begin
         push(MUL, 64'(k + 10), 4'b0000, k + 1);
         tick();
         n_total++; if (free_cnt !== 3'(3 - k)) $display("FAIL fill_free[%0d]: got %0d want %0d", k, free_cnt, 3 - k); else n_pass++;
         n_total++; if (overflow !== 1'b0) $display("FAIL fill_ovf[%0d]: got %b want 0", k, overflow); else n_pass++;
      end
      push(MUL, 64'd99, 4'b0000, 5);
      tick();
      n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else n_pass++;
      n_total++; if (free_cnt !== 3'd0) $display("FAIL ovf_free: got %0d want 0", free_cnt); else n_pass++;
      idle();
      cdb_gnt = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_total++; if (cdb_req !== 1'b1 || cdb_packet.rob_idx !== ROB_W'(k + 1) || cdb_packet.value !== 32'(k + 10))
            $display("FAIL ovf_drain[%0d]: got req=%b rob=%0d val=%0d want req=1 rob=%0d val=%0d", k, cdb_req, cdb_packet.rob_idx, cdb_packet.value, k + 1, k + 10);
         else n_pass++;
         tick();
      end
      n_total++; if (cdb_req !== 1'b0 || free_cnt !== 3'd4) $display("FAIL ovf_dropped: got req=%b free=%0d want req=0 free=4", cdb_req, free_cnt); else n_pass++;
      n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
   endtask

   task automatic test_reset_mid();
      idle();
      for (int k = 0; k < 3; k++) begin
         push(MUL, 64'(k), 4'b0000, k + 1);
         tick();
      end
      idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_total++; if (cdb_req !== 1'b0) $display("FAIL mid_rst_req: got %b want 0", cdb_req); else n_pass++;
      n_total++; if (free_cnt !== 3'd4) $display("FAIL mid_rst_free: got %0d want 4", free_cnt); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL mid_rst_ovf: got %b want 0", overflow); else n_pass++;
      tick();
      n_total++; if (cdb_req !== 1'b0 || free_cnt !== 3'd4) $display("FAIL mid_rst_hold: got req=%b free=%0d want req=0 free=4", cdb_req, free_cnt); else n_pass++;
   endtask

   task automatic test_back_to_back();
      idle();
      push(MUL, 64'd1, 4'b0000, 1);
      tick();
      push(MUL, 64'd2, 4'b0000, 2);
      tick();
      idle();
      cdb_gnt = 1'b1;
      tick();
      tick();
      n_total++; if (free_cnt !== 3'd4) $display("FAIL b2b_pre_free: got %0d want 4", free_cnt); else n_pass++;
      idle();
      for (int k = 3; k <= 6; k++) begin
         push(MUL, 64'(k), 4'b0000, k);
         tick();
      end
      n_total++; if (free_cnt !== 3'd0) $display("FAIL b2b_full: got %0d want 0", free_cnt); else n_pass++;
      for (int k = 0; k < 2; k++) begin
         push(MUL, 64'(k + 7), 4'b0000, k + 7);
         cdb_gnt = 1'b1;
         n_total++; if (cdb_req !== 1'b1 || cdb_packet.rob_idx !== ROB_W'(k + 3)) $display("FAIL b2b_head[%0d]: got req=%b rob=%0d want req=1 rob=%0d", k, cdb_req, cdb_packet.rob_idx, k + 3); else n_pass++;
         tick();
         n_total++; if (free_cnt !== 3'd0 || overflow !== 1'b0) $display("FAIL b2b_count[%0d]: got free=%0d ovf=%b want free=0 ovf=0", k, free_cnt, overflow); else n_pass++;
      end
      idle();
      cdb_gnt = 1'b1;
      for (int k = 5; k <= 8; k++) begin
         n_total++; if (cdb_req !== 1'b1 || cdb_packet.rob_idx !== ROB_W'(k) || cdb_packet.value !== 32'(k))
            $display("FAIL b2b_order[%0d]: got req=%b rob=%0d val=%0d want req=1 rob=%0d val=%0d", k, cdb_req, cdb_packet.rob_idx, cdb_packet.value, k, k);
         else n_pass++;
         tick();
      end
      n_total++; if (cdb_req !== 1'b0 || free_cnt !== 3'd4) $display("FAIL b2b_empty: got req=%b free=%0d want req=0 free=4", cdb_req, free_cnt); else n_pass++;
   endtask

   task automatic test_squash();
      logic [B_MASK_W-1:0] masks [3] = '{4'b0010, 4'b0001, 4'b0010};
      idle();
      for (int k = 0; k < 3; k++) begin
         push(MUL, 64'(k + 20), masks[k], k + 1);
         tick();
      end
      idle();
      clean_brat_en  = 1'b1;
      clean_brat_num = 2'd1;
      #1;
      n_total++; if (cdb_req !== 1'b0) $display("FAIL sq_same_cycle: got %b want 0", cdb_req); else n_pass++;
      tick();
      idle();
      cdb_gnt = 1'b1;
      n_total++; if (cdb_req !== 1'b0 || free_cnt !== 3'd1) $display("FAIL sq_drain0: got req=%b free=%0d want req=0 free=1", cdb_req, free_cnt); else n_pass++;
      tick();
      n_total++; if (cdb_req !== 1'b1 || cdb_packet.rob_idx !== 5'd2 || cdb_packet.value !== 32'd21)
         $display("FAIL sq_survivor: got req=%b rob=%0d val=%0d want req=1 rob=2 val=21", cdb_req, cdb_packet.rob_idx, cdb_packet.value);
      else n_pass++;
      tick();
      n_total++; if (cdb_req !== 1'b0 || free_cnt !== 3'd3) $display("FAIL sq_drain2: got req=%b free=%0d want req=0 free=3", cdb_req, free_cnt); else n_pass++;
      tick();
      n_total++; if (cdb_req !== 1'b0 || free_cnt !== 3'd4) $display("FAIL sq_empty: got req=%b free=%0d want req=0 free=4", cdb_req, free_cnt); else n_pass++;

      push(MUL, 64'd30, 4'b0100, 9);
      tick();
      idle();
      clean_brat_en  = 1'b1;
      clean_brat_num = 2'd2;
      cdb_gnt        = 1'b1;
      #1;
      n_total++; if (cdb_req !== 1'b0) $display("FAIL sq_vs_gnt: got %b want 0", cdb_req); else n_pass++;
      tick();
      idle();
      cdb_gnt = 1'b1;
      n_total++; if (cdb_req !== 1'b0 || free_cnt !== 3'd3) $display("FAIL sq_vs_gnt_kept: got req=%b free=%0d want req=0 free=3", cdb_req, free_cnt); else n_pass++;
      tick();
      n_total++; if (free_cnt !== 3'd4) $display("FAIL sq_vs_gnt_drain: got %0d want 4", free_cnt); else n_pass++;
   endtask

   task automatic test_bit_clean();
      idle();
      push(MUL, 64'd40, 4'b0100, 11);
      tick();
      idle();
      clean_bit_brat_en     = 2'b01;
      clean_bit_brat_num[0] = 2'd2;
      tick();
      idle();
      clean_brat_en  = 1'b1;
      clean_brat_num = 2'd2;
      #1;
      n_total++; if (cdb_req !== 1'b1 || cdb_packet.b_mask !== 4'b0000) $display("FAIL bc_cleared: got req=%b mask=%b want req=1 mask=0000", cdb_req, cdb_packet.b_mask); else n_pass++;
      tick();
      idle();
      n_total++; if (cdb_req !== 1'b1 || cdb_packet.rob_idx !== 5'd11) $display("FAIL bc_survives: got req=%b rob=%0d want req=1 rob=11", cdb_req, cdb_packet.rob_idx); else n_pass++;
      cdb_gnt = 1'b1;
      tick();
      n_total++; if (free_cnt !== 3'd4) $display("FAIL bc_pop: got %0d want 4", free_cnt); else n_pass++;

      idle();
      push(MUL, 64'd41, 4'b0101, 12);
      clean_bit_brat_en     = 2'b10;
      clean_bit_brat_num[1] = 2'd0;
      tick();
      idle();
      n_total++; if (cdb_req !== 1'b1 || cdb_packet.b_mask !== 4'b0100) $display("FAIL bc_capture: got req=%b mask=%b want req=1 mask=0100", cdb_req, cdb_packet.b_mask); else n_pass++;
      cdb_gnt = 1'b1;
      tick();
      n_total++; if (free_cnt !== 3'd4) $display("FAIL bc_capture_pop: got %0d want 4", free_cnt); else n_pass++;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_select();
      test_fill_overflow();
      test_reset_mid();
      test_back_to_back();
      test_squash();
      test_bit_clean();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mult_result_buffer.md
MULT_RESULT_BUFFER -- requirements
Module: mult_result_buffer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  XLEN  32  operand width
  DEPTH  4  result FIFO entries, power of two
  NUM_STAGE  4  multiplier pipeline depth; issue-credit accounting only
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clock  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-low: reset==0 at posedge resets
  mul_done  in  1  multiplier result valid this cycle
  mul_product  in  2*XLEN  full multiplier product
  mul_packet  in  IS_EX_PACKET  packet leaving the multiplier (valid, is_b_mask, dest_prn, rob_idx, mul_func)
  clean_brat_en  in  1  branch mispredict squash
  clean_brat_num  in  $clog2(`b_mask_reg_width)  squashing branch bit
  clean_bit_brat_en  in  `ALU_num  correctly resolved branch strobes
  clean_bit_brat_num  in  `ALU_num x $clog2(`b_mask_reg_width)  resolved branch bits
  cdb_gnt  in  1  CDB arbiter grant to this buffer
  cdb_req  out  1  head entry valid, requesting CDB
  cdb_packet  out  MUL_CDB_PACKET  head result: value, dest_prn, rob_idx, b_mask
  free_cnt  out  $clog2(DEPTH)+1  empty entries, registered
  overflow  out  1  sticky error flag

Function
REQ-003 Result select SHALL be combinational on entry: MUL -> product[XLEN-1:0]; MULH, MULHSU, MULHU -> product[2*XLEN-1:XLEN].
REQ-004 Enqueue SHALL occur when mul_done && mul_packet.valid, unless the incoming packet is squashed that same cycle (REQ-007).
REQ-005 The captured b_mask SHALL already have the bits of all same-cycle clean_bit_brat_en strobes cleared.
REQ-006 The buffer SHALL be a circular FIFO with head and tail pointers wrapping DEPTH-1 -> 0 and an explicit count; full at count==DEPTH, empty at count==0.
REQ-007 On clean_brat_en, every stored entry and any same-cycle incoming entry with b_mask[clean_brat_num]==1 SHALL have its valid bit cleared; its slot stays occupied.
REQ-008 On each clean_bit_brat_en[j], bit clean_bit_brat_num[j] SHALL be cleared in every stored entry's b_mask.
REQ-009 cdb_req SHALL equal head.valid && count!=0; cdb_packet SHALL be driven from the head entry, all-zero when empty.
REQ-010 Pop SHALL occur on cdb_req && cdb_gnt, or automatically when count!=0 && !head.valid (squashed head drained, one per cycle, no request).
REQ-011 Simultaneous push and pop SHALL be legal at any count, including full, and leave count unchanged.
REQ-012 A push while full without a pop SHALL be dropped and SHALL set overflow, which holds until reset; the issue stage guarantees this never happens by requiring free_cnt > in-flight multiplies (at most NUM_STAGE).
REQ-013 A squash in the same cycle as a grant to the squashed head SHALL take priority: no CDB broadcast of that entry and cdb_req deasserted in that cycle.
REQ-014 Latency SHALL be one cycle: a result enqueued at edge N into an empty buffer asserts cdb_req after edge N.

Reset
REQ-015 On reset==0 at a posedge, pointers, count, and all entry valid bits SHALL clear, and overflow SHALL become 0.
REQ-016 After reset, cdb_req SHALL be 0 and free_cnt SHALL be DEPTH; reset asserted mid-operation discards all entries.

Structure
REQ-017 MUL_FUNC enum (MUL, MULH, MULHSU, MULHU) and MUL_CDB_PACKET struct SHALL live in the shared sys_defs package alongside IS_EX_PACKET.
REQ-018 One sub-module, mul_result_select (combinational word select per REQ-003), SHALL be instantiated once at the FIFO write port.

Verification
REQ-019 MULHU 0xFFFFFFFF*0xFFFFFFFF (product 0xFFFFFFFE00000001), cdb_gnt=1 -> next cycle cdb_req=1, value 0xFFFFFFFE; MUL variant -> value 0x00000001.
REQ-020 Four pushes, cdb_gnt=0 -> free_cnt 4,3,2,1,0 and overflow=0; a fifth push with no grant -> overflow=1 and the entry is dropped.
REQ-021 Full buffer, push and grant in the same cycle -> count stays 4 and entries are broadcast in push order across pointer wrap.
REQ-022 Entries with b_mask 0b0010, 0b0001, 0b0010; clean_brat_en with num=1 -> only the middle entry is broadcast; squashed entries drain without cdb_req.
REQ-023 Stored b_mask 0b0100 with clean_bit_brat_en[0], num=2 -> broadcast b_mask 0b0000; a later clean_brat num=2 does not squash it.
REQ-024 Three entries stored, reset=0 for one cycle -> cdb_req=0, free_cnt=4, overflow=0.
